// File: rtl/frame_assembler_if.sv
// Request/transmit bundle between the frame assembler and its neighbours.
// Pure wiring, no latency.
// Carries no flow control of its own: req is sampled only while the assembler is idle.
interface frame_assembler_if;
    logic        req;
    logic [7:0]  dev_id;
    logic [7:0]  func;
    logic [23:0] payload;
    logic        packet_done;
    logic        busy;
    logic        tx_enable;
    logic [63:0] frame_out;
    logic [7:0]  crc_out;
    logic        frame_done;
    logic        tx_timeout;

    modport master (
        output req, dev_id, func, payload, packet_done,
        input  busy, tx_enable, frame_out, crc_out, frame_done, tx_timeout
    );

    modport slave (
        input  req, dev_id, func, payload, packet_done,
        output busy, tx_enable, frame_out, crc_out, frame_done, tx_timeout
    );
endinterface

// File: rtl/frame_assembler.sv
// Builds a 7-byte frame, appends a bit-serial CRC-8 and hands it to the transmit controller.
// Latency: req at E0 -> tx_enable/frame_out after E57; frame_done one cycle after packet_done.
// No queueing: req is ignored while busy. The WAIT_TX watchdog is built only with FRAME_ASSEMBLER_TIMEOUT_EN.
module frame_assembler #(
    parameter logic [7:0]  START_BYTE     = 8'hAA,
    parameter logic [7:0]  END_BYTE       = 8'h55,
    parameter logic [7:0]  CRC_POLY       = 8'h07,
    parameter logic [7:0]  CRC_INIT       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    frame_assembler_if.slave   bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CRC_CALC = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_TX  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]  state;
    logic [55:0] sh;
    logic [7:0]  crc;
    logic [5:0]  bit_cnt;
    logic        tx_enable_q;
    logic [63:0] frame_q;
    logic        fb;
    logic [7:0]  crc_next;

`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        tx_timeout_q;
`endif

    always_comb begin
        fb       = crc[7] ^ sh[55];
        crc_next = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end

    // The shift register rotates rather than discarding bits, so after 56
    // steps it again holds the latched bytes and serves as the frame source.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sh          <= 56'h0;
            crc         <= 8'h00;
            bit_cnt     <= 6'd0;
            tx_enable_q <= 1'b0;
            frame_q     <= 64'h0;
`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
            wd_cnt       <= 32'd0;
            tx_timeout_q <= 1'b0;
`endif
        end else begin
            tx_enable_q <= 1'b0;
`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
            tx_timeout_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        sh      <= {START_BYTE, bus.dev_id, bus.func, bus.payload, END_BYTE};
                        crc     <= CRC_INIT;
                        bit_cnt <= 6'd0;
                        state   <= S_CRC_CALC;
                    end
                end
                S_CRC_CALC: begin
                    crc     <= crc_next;
                    sh      <= {sh[54:0], sh[55]};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'd55) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    frame_q     <= {sh, crc};
                    tx_enable_q <= 1'b1;
                    state       <= S_WAIT_TX;
`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
                    wd_cnt      <= 32'd0;
`endif
                end
                S_WAIT_TX: begin
                    if (bus.packet_done) begin
                        state <= S_DONE;
                    end
`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
                    else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        tx_timeout_q <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state == S_CRC_CALC) || (state == S_ISSUE) || (state == S_WAIT_TX);
    assign bus.frame_done = (state == S_DONE);
    assign bus.tx_enable  = tx_enable_q;
    assign bus.frame_out  = frame_q;
    assign bus.crc_out    = frame_q[7:0];

`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
    assign bus.tx_timeout = tx_timeout_q;
`else
    // No watchdog in this build; the limit parameter stays overridable but has no effect.
    assign bus.tx_timeout = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler: expected frames are queued at req time,
// a negedge monitor pops and compares them whenever tx_enable is seen.
module tb_frame_assembler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_assembler_if b0 ();
    frame_assembler_if b1 ();
    frame_assembler_if b2 ();

    frame_assembler #(.TIMEOUT_CYCLES(20)) d0 (.clk(clk), .rst(rst), .bus(b0));
    frame_assembler #(.START_BYTE(8'h00), .END_BYTE(8'h00)) d1 (.clk(clk), .rst(rst), .bus(b1));
    frame_assembler #(.START_BYTE(8'h00), .END_BYTE(8'h01)) d2 (.clk(clk), .rst(rst), .bus(b2));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_txen0  = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [63:0] e0, e1, e2;
    logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic flag(input string nm);
        n_checks++;
        $display("FAIL %s: event seen where none was required", nm);
    endtask

    // Byte-oriented reference CRC-8 (poly 0x07, init 0, no reflection).
    function automatic logic [7:0] crc8(input logic [55:0] bytes);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 6; i >= 0; i--) begin
            c = c ^ bytes[i*8 +: 8];
            for (int b = 0; b < 8; b++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [63:0] exp_frame(input logic [7:0] id, input logic [7:0] fn, input logic [23:0] pl);
        logic [55:0] body;
        body = {8'hAA, id, fn, pl, 8'h55};
        return {body, crc8(body)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (b0.tx_enable) begin
                n_txen0++;
                check("txen0_single_cycle", {63'd0, prev0}, 64'd0);
                if (q0.size() == 0) flag("txen0_unexpected");
                else begin
                    e0 = q0.pop_front();
                    check("frame0", b0.frame_out, e0);
                    check("crc0", {56'd0, b0.crc_out}, {56'd0, e0[7:0]});
                end
            end
            if (b1.tx_enable) begin
                if (q1.size() == 0) flag("txen1_unexpected");
                else begin
                    e1 = q1.pop_front();
                    check("frame1", b1.frame_out, e1);
                    check("crc1", {56'd0, b1.crc_out}, {56'd0, e1[7:0]});
                end
            end
            if (b2.tx_enable) begin
                if (q2.size() == 0) flag("txen2_unexpected");
                else begin
                    e2 = q2.pop_front();
                    check("frame2", b2.frame_out, e2);
                    check("crc2", {56'd0, b2.crc_out}, {56'd0, e2[7:0]});
                end
            end
        end
        prev0 = b0.tx_enable;
        prev1 = b1.tx_enable;
        prev2 = b2.tx_enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_txen0(output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (b0.tx_enable) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) flag("txen0_wait_expired");
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        int n0, t1, t2, pd_c, seen;
        b0.req = 0; b0.dev_id = 0; b0.func = 0; b0.payload = 0; b0.packet_done = 0;
        b1.req = 0; b1.dev_id = 0; b1.func = 0; b1.payload = 0; b1.packet_done = 0;
        b2.req = 0; b2.dev_id = 0; b2.func = 0; b2.payload = 0; b2.packet_done = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", {63'd0, b0.busy}, 64'd0);
        check("rst_txen", {63'd0, b0.tx_enable}, 64'd0);
        check("rst_frame", b0.frame_out, 64'd0);
        check("rst_crc", {56'd0, b0.crc_out}, 64'd0);
        check("rst_done_timeout", {62'd0, b0.frame_done, b0.tx_timeout}, 64'd0);

        // CRC vectors with zero start/end bytes
        b1.payload = 24'h000001;
        b2.payload = 24'h000000;
        q1.push_back(64'h0000_0000_0001_0015);
        q2.push_back(64'h0000_0000_0000_0107);
        b1.req = 1; b2.req = 1;
        tick();
        b1.req = 0; b2.req = 0;
        repeat (60) tick();
        b1.packet_done = 1; b2.packet_done = 1;
        tick();
        b1.packet_done = 0; b2.packet_done = 0;
        check("aux1_frame_done", {63'd0, b1.frame_done}, 64'd1);
        check("aux2_frame_done", {63'd0, b2.frame_done}, 64'd1);
        check("aux1_busy_low", {63'd0, b1.busy}, 64'd0);

        // Reset in the middle of CRC_CALC abandons the frame
        b0.dev_id = 8'h99; b0.req = 1;
        tick();
        b0.req = 0;
        repeat (10) tick();
        check("midcrc_busy", {63'd0, b0.busy}, 64'd1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("midrst_busy", {63'd0, b0.busy}, 64'd0);
        check("midrst_frame", b0.frame_out, 64'd0);
        n0 = n_txen0;
        repeat (70) tick();
        check("midrst_no_txen", n_txen0, n0);

        // Timing, hold and ignore rules
        n0 = n_txen0;
        b0.dev_id = 8'h11; b0.func = 8'h22; b0.payload = 24'h334455; b0.req = 1;
        q0.push_back(exp_frame(8'h11, 8'h22, 24'h334455));
        tick();
        b0.req = 0;
        check("busy_after_E0", {63'd0, b0.busy}, 64'd1);
        b0.dev_id = 8'hFF; b0.func = 8'hEE; b0.payload = 24'hDDCCBB;
        b0.packet_done = 1;
        tick();
        b0.packet_done = 0;
        repeat (55) tick();
        check("txen_low_E56", {63'd0, b0.tx_enable}, 64'd0);
        tick();
        check("txen_high_E57", {63'd0, b0.tx_enable}, 64'd1);
        check("frame_bytes_E57", {8'd0, b0.frame_out[63:8]}, {8'd0, 56'hAA_11_22_33_44_55_55});
        tick();
        check("txen_low_E58", {63'd0, b0.tx_enable}, 64'd0);
        check("busy_wait_tx", {63'd0, b0.busy}, 64'd1);
        b0.req = 1; b0.dev_id = 8'h01; b0.func = 8'h02; b0.payload = 24'h030405;
        repeat (5) tick();
        b0.req = 0;
        repeat (5) tick();
        check("hold_frame", b0.frame_out, exp_frame(8'h11, 8'h22, 24'h334455));
        check("hold_single_txen", n_txen0, n0 + 1);
        b0.packet_done = 1;
        tick();
        b0.packet_done = 0;
        check("frame_done_pulse", {63'd0, b0.frame_done}, 64'd1);
        check("busy_falls", {63'd0, b0.busy}, 64'd0);
        tick();
        check("frame_done_ends", {63'd0, b0.frame_done}, 64'd0);

        // Back-to-back with req held high
        n0 = n_txen0;
        b0.dev_id = 8'hA1; b0.func = 8'hB2; b0.payload = 24'hC3D4E5; b0.req = 1;
        q0.push_back(exp_frame(8'hA1, 8'hB2, 24'hC3D4E5));
        q0.push_back(exp_frame(8'h5A, 8'h6B, 24'h7C8D9E));
        tick();
        b0.dev_id = 8'h5A; b0.func = 8'h6B; b0.payload = 24'h7C8D9E;
        wait_txen0(t1);
        repeat (3) tick();
        b0.packet_done = 1;
        tick();
        pd_c = cyc;
        b0.packet_done = 0;
        wait_txen0(t2);
        check("b2b_gap_edges", t2 - pd_c, 59);
        b0.req = 0;
        repeat (3) tick();
        b0.packet_done = 1;
        tick();
        b0.packet_done = 0;
        check("b2b_frame_done", {63'd0, b0.frame_done}, 64'd1);
        tick();
        check("b2b_two_txen", n_txen0, n0 + 2);

        // Watchdog behaviour
        b0.dev_id = 8'h77; b0.func = 8'h88; b0.payload = 24'h99AABB; b0.req = 1;
        q0.push_back(exp_frame(8'h77, 8'h88, 24'h99AABB));
        tick();
        b0.req = 0;
        wait_txen0(t1);
`ifdef FRAME_ASSEMBLER_TIMEOUT_EN
        repeat (19) tick();
        check("timeout_not_early", {63'd0, b0.tx_timeout}, 64'd0);
        tick();
        check("timeout_pulse", {63'd0, b0.tx_timeout}, 64'd1);
        check("timeout_busy_low", {63'd0, b0.busy}, 64'd0);
        check("timeout_no_frame_done", {63'd0, b0.frame_done}, 64'd0);
        check("timeout_frame_kept", b0.frame_out, exp_frame(8'h77, 8'h88, 24'h99AABB));
        tick();
        check("timeout_pulse_ends", {63'd0, b0.tx_timeout}, 64'd0);
`else
        seen = 0;
        repeat (40) begin
            tick();
            if (b0.tx_timeout) seen++;
        end
        check("no_timeout_pulse", seen, 0);
        check("no_timeout_busy", {63'd0, b0.busy}, 64'd1);
        b0.packet_done = 1;
        tick();
        b0.packet_done = 0;
        check("late_frame_done", {63'd0, b0.frame_done}, 64'd1);
`endif
        tick();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
